prc_frame_scheduler: RTL and testbench

Sequences the packet reader core through a ring of frame buffers. Per frame it optionally issues one control packet (type 15), then one video packet (type 0) from the current buffer, and advances the buffer index. It owns the core's GO/clear/complete handshake and double-buffers host configuration, so new settings take effect only at frame boundaries. It sits between the Avalon-MM control slave decode and the packet reader core.

---
 rtl/prc_sched_pkg.sv | 39 +++
 rtl/prc_sched_regs.sv | 129 ++++++++++++
 rtl/prc_frame_scheduler.sv | 192 +++++++++++++++++++
 tb/tb_prc_frame_scheduler.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prc_sched_pkg.sv
// Shared constants for the packet-reader frame scheduler: register map,
// packet type codes, FSM state encoding and the frame-index wrap helper.
package prc_sched_pkg;

  localparam int unsigned ADDR_WIDTH    = 32;
  localparam int unsigned REG_IDX_WIDTH = 4;
  localparam int unsigned FRAME_IDX_W   = 3;
  localparam int unsigned FRAME_SLOTS   = 8;
  localparam int unsigned STATE_WIDTH   = 3;

  localparam logic [REG_IDX_WIDTH-1:0] REG_CTRL         = 4'd0;
  localparam logic [REG_IDX_WIDTH-1:0] REG_NUM_FRAMES   = 4'd1;
  localparam logic [REG_IDX_WIDTH-1:0] REG_CTRL_ADDR    = 4'd2;
  localparam logic [REG_IDX_WIDTH-1:0] REG_CTRL_WORDS   = 4'd3;
  localparam logic [REG_IDX_WIDTH-1:0] REG_CTRL_SAMPLES = 4'd4;
  localparam logic [REG_IDX_WIDTH-1:0] REG_VID_WORDS    = 4'd5;
  localparam logic [REG_IDX_WIDTH-1:0] REG_VID_SAMPLES  = 4'd6;
  localparam logic [REG_IDX_WIDTH-1:0] REG_COMMIT       = 4'd7;
  localparam logic [REG_IDX_WIDTH-1:0] REG_FRAME0       = 4'd8;

  localparam logic [3:0] PKT_TYPE_CTRL  = 4'hF;
  localparam logic [3:0] PKT_TYPE_VIDEO = 4'h0;

  localparam logic [STATE_WIDTH-1:0] S_IDLE       = 3'd0;
  localparam logic [STATE_WIDTH-1:0] S_ISSUE_CTRL = 3'd1;
  localparam logic [STATE_WIDTH-1:0] S_WAIT_CTRL  = 3'd2;
  localparam logic [STATE_WIDTH-1:0] S_ISSUE_VID  = 3'd3;
  localparam logic [STATE_WIDTH-1:0] S_WAIT_VID   = 3'd4;
  localparam logic [STATE_WIDTH-1:0] S_NEXT       = 3'd5;

  // Wrap to 0 at or past the last slot, so a shrunk ring recovers on the next frame.
  function automatic logic [FRAME_IDX_W-1:0] next_frame_idx(
    input logic [FRAME_IDX_W-1:0] cur,
    input logic [FRAME_IDX_W-1:0] last
  );
    return (cur >= last) ? 3'd0 : cur + 3'd1;
  endfunction

endpackage

// File: rtl/prc_sched_regs.sv
// Host configuration banks: live control bits plus a shadow/active pair that
// only swaps at frame boundaries when a commit is pending.
module prc_sched_regs
  import prc_sched_pkg::*;
#(
  parameter int unsigned MAX_FRAMES = 4,
  parameter int unsigned BURST_W    = 7,
  parameter int unsigned SAMPLES_W  = 32
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_cfg_write,
  input  logic [REG_IDX_WIDTH-1:0] i_cfg_address,
  input  logic [31:0]              i_cfg_writedata,
  input  logic                     i_apply_ok,
  input  logic [FRAME_IDX_W-1:0]   i_frame_sel,
  output logic                     o_go,
  output logic                     o_ctrl_pkt_en,
  output logic                     o_irq_en,
  output logic [FRAME_IDX_W-1:0]   o_num_frames_m1,
  output logic [ADDR_WIDTH-1:0]    o_ctrl_addr,
  output logic [BURST_W-1:0]       o_ctrl_words,
  output logic [SAMPLES_W-1:0]     o_ctrl_samples,
  output logic [BURST_W-1:0]       o_vid_words,
  output logic [SAMPLES_W-1:0]     o_vid_samples,
  output logic [ADDR_WIDTH-1:0]    o_frame_addr_c
);

  logic                   r_go;
  logic                   r_ctrl_pkt_en;
  logic                   r_irq_en;
  logic                   r_commit_pending;

  logic [FRAME_IDX_W-1:0] r_shd_num_m1;
  logic [ADDR_WIDTH-1:0]  r_shd_ctrl_addr;
  logic [BURST_W-1:0]     r_shd_ctrl_words;
  logic [SAMPLES_W-1:0]   r_shd_ctrl_samples;
  logic [BURST_W-1:0]     r_shd_vid_words;
  logic [SAMPLES_W-1:0]   r_shd_vid_samples;
  logic [ADDR_WIDTH-1:0]  r_shd_frame [FRAME_SLOTS];

  logic [FRAME_IDX_W-1:0] r_act_num_m1;
  logic [ADDR_WIDTH-1:0]  r_act_ctrl_addr;
  logic [BURST_W-1:0]     r_act_ctrl_words;
  logic [SAMPLES_W-1:0]   r_act_ctrl_samples;
  logic [BURST_W-1:0]     r_act_vid_words;
  logic [SAMPLES_W-1:0]   r_act_vid_samples;
  logic [ADDR_WIDTH-1:0]  r_act_frame [FRAME_SLOTS];

  logic                   w_copy;
  logic                   w_commit_wr;
  logic                   w_frame_hit;
  logic [FRAME_IDX_W-1:0] w_frame_idx;
  logic [FRAME_IDX_W-1:0] w_num_m1_clamped;

  assign w_copy      = i_apply_ok & r_commit_pending;
  assign w_commit_wr = i_cfg_write & (i_cfg_address == REG_COMMIT);
  assign w_frame_idx = i_cfg_address[FRAME_IDX_W-1:0];
  assign w_frame_hit = i_cfg_address[3] & (32'(w_frame_idx) < MAX_FRAMES);
  assign w_num_m1_clamped = (i_cfg_writedata >= 32'(MAX_FRAMES)) ?
                            FRAME_IDX_W'(MAX_FRAMES - 1) : i_cfg_writedata[FRAME_IDX_W-1:0];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_go               <= 1'b0;
      r_ctrl_pkt_en      <= 1'b0;
      r_irq_en           <= 1'b0;
      r_commit_pending   <= 1'b0;
      r_shd_num_m1       <= '0;
      r_shd_ctrl_addr    <= '0;
      r_shd_ctrl_words   <= '0;
      r_shd_ctrl_samples <= '0;
      r_shd_vid_words    <= '0;
      r_shd_vid_samples  <= '0;
      r_act_num_m1       <= '0;
      r_act_ctrl_addr    <= '0;
      r_act_ctrl_words   <= '0;
      r_act_ctrl_samples <= '0;
      r_act_vid_words    <= '0;
      r_act_vid_samples  <= '0;
      for (int i = 0; i < FRAME_SLOTS; i++) begin
        r_shd_frame[i] <= '0;
        r_act_frame[i] <= '0;
      end
    end else begin
      if (i_cfg_write) begin
        case (i_cfg_address)
          REG_CTRL: begin
            r_go          <= i_cfg_writedata[0];
            r_ctrl_pkt_en <= i_cfg_writedata[1];
            r_irq_en      <= i_cfg_writedata[2];
          end
          REG_NUM_FRAMES:   r_shd_num_m1       <= w_num_m1_clamped;
          REG_CTRL_ADDR:    r_shd_ctrl_addr    <= i_cfg_writedata;
          REG_CTRL_WORDS:   r_shd_ctrl_words   <= BURST_W'(i_cfg_writedata);
          REG_CTRL_SAMPLES: r_shd_ctrl_samples <= SAMPLES_W'(i_cfg_writedata);
          REG_VID_WORDS:    r_shd_vid_words    <= BURST_W'(i_cfg_writedata);
          REG_VID_SAMPLES:  r_shd_vid_samples  <= SAMPLES_W'(i_cfg_writedata);
          default: begin
            if (w_frame_hit) r_shd_frame[w_frame_idx] <= i_cfg_writedata;
          end
        endcase
      end
      // Copy samples the shadow as it stood before any same-cycle write.
      if (w_copy) begin
        r_act_num_m1       <= r_shd_num_m1;
        r_act_ctrl_addr    <= r_shd_ctrl_addr;
        r_act_ctrl_words   <= r_shd_ctrl_words;
        r_act_ctrl_samples <= r_shd_ctrl_samples;
        r_act_vid_words    <= r_shd_vid_words;
        r_act_vid_samples  <= r_shd_vid_samples;
        for (int i = 0; i < FRAME_SLOTS; i++) r_act_frame[i] <= r_shd_frame[i];
      end
      r_commit_pending <= w_commit_wr | (r_commit_pending & ~w_copy);
    end
  end

  assign o_go            = r_go;
  assign o_ctrl_pkt_en   = r_ctrl_pkt_en;
  assign o_irq_en        = r_irq_en;
  assign o_num_frames_m1 = r_act_num_m1;
  assign o_ctrl_addr     = r_act_ctrl_addr;
  assign o_ctrl_words    = r_act_ctrl_words;
  assign o_ctrl_samples  = r_act_ctrl_samples;
  assign o_vid_words     = r_act_vid_words;
  assign o_vid_samples   = r_act_vid_samples;
  assign o_frame_addr_c  = r_act_frame[i_frame_sel];

endmodule

// File: rtl/prc_frame_scheduler.sv
// Frame scheduler: walks the frame-buffer ring, issuing an optional control
// packet then one video packet per frame through the core's GO/clear/complete handshake.
module prc_frame_scheduler
  import prc_sched_pkg::*;
#(
  parameter int unsigned MAX_FRAMES                   = 4,
  parameter int unsigned BURST_LENGTH_REQUIREDWIDTH   = 7,
  parameter int unsigned PACKET_SAMPLES_REQUIREDWIDTH = 32
) (
  input  logic                                    clock,
  input  logic                                    reset_n,
  input  logic                                    cfg_write,
  input  logic [3:0]                              cfg_address,
  input  logic [31:0]                             cfg_writedata,
  output logic                                    go,
  output logic                                    running,
  output logic                                    irq,
  output logic [15:0]                             frames_done,
  output logic [2:0]                              cur_frame,
  output logic                                    core_enable,
  input  logic                                    core_clear_enable,
  input  logic                                    core_stopped,
  input  logic                                    core_complete,
  output logic [31:0]                             packet_addr,
  output logic [3:0]                              packet_type,
  output logic [PACKET_SAMPLES_REQUIREDWIDTH-1:0] packet_samples,
  output logic [BURST_LENGTH_REQUIREDWIDTH-1:0]   packet_words
);

  localparam int unsigned SW = PACKET_SAMPLES_REQUIREDWIDTH;
  localparam int unsigned BW = BURST_LENGTH_REQUIREDWIDTH;

  logic [STATE_WIDTH-1:0] r_state;
  logic                   r_core_enable;
  logic                   r_running;
  logic                   r_irq;
  logic [15:0]            r_frames_done;
  logic [FRAME_IDX_W-1:0] r_cur_frame;
  logic [ADDR_WIDTH-1:0]  r_pkt_addr;
  logic [3:0]             r_pkt_type;
  logic [SW-1:0]          r_pkt_samples;
  logic [BW-1:0]          r_pkt_words;

  logic [STATE_WIDTH-1:0] w_state_nxt;
  logic                   w_core_enable_nxt;
  logic                   w_running_nxt;
  logic                   w_irq_nxt;
  logic [15:0]            w_frames_done_nxt;
  logic [FRAME_IDX_W-1:0] w_cur_frame_nxt;
  logic [ADDR_WIDTH-1:0]  w_pkt_addr_nxt;
  logic [3:0]             w_pkt_type_nxt;
  logic [SW-1:0]          w_pkt_samples_nxt;
  logic [BW-1:0]          w_pkt_words_nxt;
  logic                   w_apply_ok;

  logic                   w_go;
  logic                   w_ctrl_pkt_en;
  logic                   w_irq_en;
  logic [FRAME_IDX_W-1:0] w_num_frames_m1;
  logic [ADDR_WIDTH-1:0]  w_ctrl_addr;
  logic [BW-1:0]          w_ctrl_words;
  logic [SW-1:0]          w_ctrl_samples;
  logic [BW-1:0]          w_vid_words;
  logic [SW-1:0]          w_vid_samples;
  logic [ADDR_WIDTH-1:0]  w_frame_addr_c;

  prc_sched_regs #(
    .MAX_FRAMES (MAX_FRAMES),
    .BURST_W    (BW),
    .SAMPLES_W  (SW)
  ) u_regs (
    .i_clk           (clock),
    .i_rst_n         (reset_n),
    .i_cfg_write     (cfg_write),
    .i_cfg_address   (cfg_address),
    .i_cfg_writedata (cfg_writedata),
    .i_apply_ok      (w_apply_ok),
    .i_frame_sel     (r_cur_frame),
    .o_go            (w_go),
    .o_ctrl_pkt_en   (w_ctrl_pkt_en),
    .o_irq_en        (w_irq_en),
    .o_num_frames_m1 (w_num_frames_m1),
    .o_ctrl_addr     (w_ctrl_addr),
    .o_ctrl_words    (w_ctrl_words),
    .o_ctrl_samples  (w_ctrl_samples),
    .o_vid_words     (w_vid_words),
    .o_vid_samples   (w_vid_samples),
    .o_frame_addr_c  (w_frame_addr_c)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_core_enable <= 1'b0;
      r_running     <= 1'b0;
      r_irq         <= 1'b0;
      r_frames_done <= '0;
      r_cur_frame   <= '0;
      r_pkt_addr    <= '0;
      r_pkt_type    <= '0;
      r_pkt_samples <= '0;
      r_pkt_words   <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_core_enable <= w_core_enable_nxt;
      r_running     <= w_running_nxt;
      r_irq         <= w_irq_nxt;
      r_frames_done <= w_frames_done_nxt;
      r_cur_frame   <= w_cur_frame_nxt;
      r_pkt_addr    <= w_pkt_addr_nxt;
      r_pkt_type    <= w_pkt_type_nxt;
      r_pkt_samples <= w_pkt_samples_nxt;
      r_pkt_words   <= w_pkt_words_nxt;
    end
  end

  // Packet fields load only in ISSUE, so they hold through the whole WAIT.
  always_comb begin
    w_state_nxt       = r_state;
    w_core_enable_nxt = r_core_enable;
    w_running_nxt     = r_running;
    w_irq_nxt         = 1'b0;
    w_frames_done_nxt = r_frames_done;
    w_cur_frame_nxt   = r_cur_frame;
    w_pkt_addr_nxt    = r_pkt_addr;
    w_pkt_type_nxt    = r_pkt_type;
    w_pkt_samples_nxt = r_pkt_samples;
    w_pkt_words_nxt   = r_pkt_words;
    w_apply_ok        = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_running_nxt = 1'b0;
        w_apply_ok    = 1'b1;
        if (w_go && core_stopped) begin
          w_state_nxt = w_ctrl_pkt_en ? S_ISSUE_CTRL : S_ISSUE_VID;
        end
      end
      S_ISSUE_CTRL: begin
        w_pkt_addr_nxt    = w_ctrl_addr;
        w_pkt_type_nxt    = PKT_TYPE_CTRL;
        w_pkt_samples_nxt = w_ctrl_samples;
        w_pkt_words_nxt   = w_ctrl_words;
        w_core_enable_nxt = 1'b1;
        w_running_nxt     = 1'b1;
        w_state_nxt       = S_WAIT_CTRL;
      end
      S_WAIT_CTRL: begin
        if (core_clear_enable || core_complete) w_core_enable_nxt = 1'b0;
        if (core_complete) w_state_nxt = S_ISSUE_VID;
      end
      S_ISSUE_VID: begin
        w_pkt_addr_nxt    = w_frame_addr_c;
        w_pkt_type_nxt    = PKT_TYPE_VIDEO;
        w_pkt_samples_nxt = w_vid_samples;
        w_pkt_words_nxt   = w_vid_words;
        w_core_enable_nxt = 1'b1;
        w_running_nxt     = 1'b1;
        w_state_nxt       = S_WAIT_VID;
      end
      S_WAIT_VID: begin
        if (core_clear_enable || core_complete) w_core_enable_nxt = 1'b0;
        if (core_complete) w_state_nxt = S_NEXT;
      end
      S_NEXT: begin
        w_frames_done_nxt = r_frames_done + 16'd1;
        w_irq_nxt         = w_irq_en;
        w_cur_frame_nxt   = next_frame_idx(r_cur_frame, w_num_frames_m1);
        w_apply_ok        = 1'b1;
        if (w_go) begin
          w_state_nxt = w_ctrl_pkt_en ? S_ISSUE_CTRL : S_ISSUE_VID;
        end else begin
          w_state_nxt   = S_IDLE;
          w_running_nxt = 1'b0;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign go             = w_go;
  assign running        = r_running;
  assign irq            = r_irq;
  assign frames_done    = r_frames_done;
  assign cur_frame      = r_cur_frame;
  assign core_enable    = r_core_enable;
  assign packet_addr    = r_pkt_addr;
  assign packet_type    = r_pkt_type;
  assign packet_samples = r_pkt_samples;
  assign packet_words   = r_pkt_words;

endmodule

// File: tb/tb_prc_frame_scheduler.sv
// Directed bench for prc_frame_scheduler with a simple packet-reader core model
// that accepts each GO, then reports completion five cycles later.
module tb_prc_frame_scheduler;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        cfg_write;
  logic [3:0]  cfg_address;
  logic [31:0] cfg_writedata;
  logic        go, running, irq, core_enable;
  logic [15:0] frames_done;
  logic [2:0]  cur_frame;
  logic        core_clear_enable, core_stopped, core_complete;
  logic [31:0] packet_addr;
  logic [3:0]  packet_type;
  logic [31:0] packet_samples;
  logic [6:0]  packet_words;

  always #5 clock = ~clock;

  prc_frame_scheduler #(
    .MAX_FRAMES                   (4),
    .BURST_LENGTH_REQUIREDWIDTH   (7),
    .PACKET_SAMPLES_REQUIREDWIDTH (32)
  ) dut (
    .clock             (clock),
    .reset_n           (reset_n),
    .cfg_write         (cfg_write),
    .cfg_address       (cfg_address),
    .cfg_writedata     (cfg_writedata),
    .go                (go),
    .running           (running),
    .irq               (irq),
    .frames_done       (frames_done),
    .cur_frame         (cur_frame),
    .core_enable       (core_enable),
    .core_clear_enable (core_clear_enable),
    .core_stopped      (core_stopped),
    .core_complete     (core_complete),
    .packet_addr       (packet_addr),
    .packet_type       (packet_type),
    .packet_samples    (packet_samples),
    .packet_words      (packet_words)
  );

  int n_chk = 0;
  int n_fail = 0;

  logic [31:0] lg_addr  [128];
  logic [3:0]  lg_type  [128];
  logic [31:0] lg_samp  [128];
  logic [6:0]  lg_words [128];
  logic [2:0]  lg_cur   [128];
  logic [15:0] lg_fd    [128];
  int          lg_cyc   [128];
  int          lg_done  [128];
  int          irq_at   [128];
  int          pkt_cnt = 0;
  int          irq_cnt = 0;
  int          cyc = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Core model: ack GO with a one-cycle clear, complete five cycles later.
  initial begin
    int  cnt;
    bit  busy;
    busy = 0;
    cnt = 0;
    core_clear_enable = 1'b0;
    core_complete     = 1'b0;
    core_stopped      = 1'b1;
    forever begin
      @(negedge clock);
      cyc++;
      core_clear_enable = 1'b0;
      core_complete     = 1'b0;
      if (!reset_n) begin
        busy = 0;
        core_stopped = 1'b1;
      end else if (busy) begin
        cnt++;
        if (cnt == 5) begin
          core_complete = 1'b1;
          if (pkt_cnt > 0 && pkt_cnt <= 128) lg_done[pkt_cnt-1] = cyc;
        end else if (cnt == 6) begin
          busy = 0;
          core_stopped = 1'b1;
        end
      end else if (core_enable) begin
        if (pkt_cnt < 128) begin
          lg_addr[pkt_cnt]  = packet_addr;
          lg_type[pkt_cnt]  = packet_type;
          lg_samp[pkt_cnt]  = packet_samples;
          lg_words[pkt_cnt] = packet_words;
          lg_cur[pkt_cnt]   = cur_frame;
          lg_fd[pkt_cnt]    = frames_done;
          lg_cyc[pkt_cnt]   = cyc;
        end
        pkt_cnt++;
        core_clear_enable = 1'b1;
        core_stopped      = 1'b0;
        busy = 1;
        cnt  = 0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clock);
      if (irq === 1'b1) begin
        if (irq_cnt < 128) irq_at[irq_cnt] = pkt_cnt;
        irq_cnt++;
      end
    end
  end

  task automatic cfg_wr(input logic [3:0] a, input logic [31:0] d);
    cfg_write     = 1'b1;
    cfg_address   = a;
    cfg_writedata = d;
    @(negedge clock);
    cfg_write     = 1'b0;
  endtask

  task automatic cfg_base(input logic [31:0] num_m1);
    cfg_wr(4'd1, num_m1);
    for (int k = 0; k < 4; k++) cfg_wr(4'(8 + k), 32'h1000 * 32'(k + 1));
    cfg_wr(4'd5, 32'd16);
    cfg_wr(4'd6, 32'd64);
    cfg_wr(4'd2, 32'h800);
    cfg_wr(4'd3, 32'd2);
    cfg_wr(4'd4, 32'd4);
    cfg_wr(4'd7, 32'd1);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
  endtask

  task automatic wait_pkts(input int n, input string tag);
    int k;
    k = 0;
    while (pkt_cnt < n && k < 400) begin
      @(negedge clock);
      k++;
    end
    chk(tag, 32'(pkt_cnt >= n), 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while (running !== 1'b0 && k < 400) begin
      @(negedge clock);
      k++;
    end
    chk(tag, 32'(running), 32'd0);
  endtask

  initial begin
    int pb;
    int ib;
    cfg_write = 1'b0;
    cfg_address = '0;
    cfg_writedata = '0;
    reset_n = 1'b0;
    repeat (3) @(negedge clock);

    chk("rst_go", 32'(go), 32'd0);
    chk("rst_running", 32'(running), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_frames_done", 32'(frames_done), 32'd0);
    chk("rst_cur_frame", 32'(cur_frame), 32'd0);
    chk("rst_core_enable", 32'(core_enable), 32'd0);
    chk("rst_packet_addr", packet_addr, 32'd0);
    chk("rst_packet_type", 32'(packet_type), 32'd0);
    chk("rst_packet_samples", packet_samples, 32'd0);
    chk("rst_packet_words", 32'(packet_words), 32'd0);
    reset_n = 1'b1;
    @(negedge clock);

    // Video-only ring of three buffers, GO latency and complete-to-GO gap.
    pb = pkt_cnt;
    ib = irq_cnt;
    cfg_base(32'd2);
    cfg_wr(4'd0, 32'd1);
    chk("t1_go_reg", 32'(go), 32'd1);
    chk("t1_go_lat0", 32'(core_enable), 32'd0);
    @(negedge clock);
    chk("t1_go_lat1", 32'(core_enable), 32'd0);
    @(negedge clock);
    chk("t1_go_lat2", 32'(core_enable), 32'd1);
    wait_pkts(pb + 4, "t1_pkts");
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t1_addr%0d", i), lg_addr[pb+i], 32'h1000 * 32'((i % 3) + 1));
      chk($sformatf("t1_type%0d", i), 32'(lg_type[pb+i]), 32'd0);
      chk($sformatf("t1_samp%0d", i), lg_samp[pb+i], 32'd64);
      chk($sformatf("t1_words%0d", i), 32'(lg_words[pb+i]), 32'd16);
      chk($sformatf("t1_fd%0d", i), 32'(lg_fd[pb+i]), 32'(i));
      chk($sformatf("t1_cur%0d", i), 32'(lg_cur[pb+i]), 32'(i % 3));
    end
    chk("t1_complete_gap", 32'(lg_cyc[pb+1] - lg_done[pb]), 32'd3);
    chk("t1_no_irq", 32'(irq_cnt - ib), 32'd0);

    // Control packet ahead of every video packet, irq after video only.
    do_reset();
    pb = pkt_cnt;
    ib = irq_cnt;
    cfg_base(32'd2);
    cfg_wr(4'd0, 32'd7);
    wait_pkts(pb + 5, "t2_pkts");
    for (int i = 0; i < 5; i++) begin
      if (i % 2 == 0) begin
        chk($sformatf("t2_type%0d", i), 32'(lg_type[pb+i]), 32'hF);
        chk($sformatf("t2_addr%0d", i), lg_addr[pb+i], 32'h800);
        chk($sformatf("t2_samp%0d", i), lg_samp[pb+i], 32'd4);
        chk($sformatf("t2_words%0d", i), 32'(lg_words[pb+i]), 32'd2);
      end else begin
        chk($sformatf("t2_type%0d", i), 32'(lg_type[pb+i]), 32'h0);
        chk($sformatf("t2_addr%0d", i), lg_addr[pb+i], 32'h1000 * 32'((i / 2) + 1));
        chk($sformatf("t2_samp%0d", i), lg_samp[pb+i], 32'd64);
      end
    end
    chk("t2_irq_cnt", 32'(irq_cnt - ib), 32'd2);
    chk("t2_irq_at0", 32'(irq_at[ib] - pb), 32'd2);
    chk("t2_irq_at1", 32'(irq_at[ib+1] - pb), 32'd4);

    // Mid-frame commit takes effect from the following frame.
    do_reset();
    pb = pkt_cnt;
    cfg_base(32'd2);
    cfg_wr(4'd0, 32'd1);
    wait_pkts(pb + 2, "t3_pkts_a");
    cfg_wr(4'd6, 32'd100);
    cfg_wr(4'd7, 32'd1);
    wait_pkts(pb + 4, "t3_pkts_b");
    chk("t3_samp1_old", lg_samp[pb+1], 32'd64);
    chk("t3_samp2_new", lg_samp[pb+2], 32'd100);
    chk("t3_samp3_new", lg_samp[pb+3], 32'd100);
    chk("t3_addr2", lg_addr[pb+2], 32'h3000);

    // Clearing go during the control packet still completes the frame.
    do_reset();
    pb = pkt_cnt;
    cfg_base(32'd2);
    cfg_wr(4'd0, 32'd3);
    wait_pkts(pb + 1, "t4_pkts");
    cfg_wr(4'd0, 32'd2);
    wait_idle("t4_idle_timeout");
    repeat (20) @(negedge clock);
    chk("t4_pkt_count", 32'(pkt_cnt - pb), 32'd2);
    chk("t4_vid_type", 32'(lg_type[pb+1]), 32'd0);
    chk("t4_vid_addr", lg_addr[pb+1], 32'h1000);
    chk("t4_running", 32'(running), 32'd0);
    chk("t4_core_enable", 32'(core_enable), 32'd0);
    chk("t4_frames_done", 32'(frames_done), 32'd1);
    chk("t4_cur_frame", 32'(cur_frame), 32'd1);
    chk("t4_go", 32'(go), 32'd0);

    // Out-of-range frame count clamps to MAX_FRAMES-1.
    do_reset();
    pb = pkt_cnt;
    cfg_base(32'd9);
    cfg_wr(4'd0, 32'd1);
    wait_pkts(pb + 5, "t5_pkts");
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("t5_cur%0d", i), 32'(lg_cur[pb+i]), 32'(i % 4));
      chk($sformatf("t5_addr%0d", i), lg_addr[pb+i], 32'h1000 * 32'((i % 4) + 1));
    end

    // Asynchronous reset while a video packet is outstanding.
    wait_pkts(pb + 6, "t6_pkts");
    chk("t6_pre_cur", 32'(cur_frame), 32'd1);
    chk("t6_pre_core_enable", 32'(core_enable), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("t6_core_enable", 32'(core_enable), 32'd0);
    chk("t6_running", 32'(running), 32'd0);
    chk("t6_cur_frame", 32'(cur_frame), 32'd0);
    chk("t6_frames_done", 32'(frames_done), 32'd0);
    chk("t6_packet_addr", packet_addr, 32'd0);
    chk("t6_packet_samples", packet_samples, 32'd0);
    chk("t6_go", 32'(go), 32'd0);
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    pb = pkt_cnt;
    cfg_base(32'd3);
    cfg_wr(4'd0, 32'd1);
    wait_pkts(pb + 1, "t6_restart_pkts");
    chk("t6_restart_cur", 32'(lg_cur[pb]), 32'd0);
    chk("t6_restart_addr", lg_addr[pb], 32'h1000);
    chk("t6_restart_fd", 32'(lg_fd[pb]), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
